// File: rtl/huffman_axil_regs.sv
// AXI4-Lite register file for the Huffman IP: NUM_REGS R/W words plus a read-only status word.
// Build option HUFFMAN_AXIL_SLVERR_EN: unmapped accesses answer SLVERR instead of OKAY.

module huffman_axil_reg_word #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     q,
  output logic                  pulse
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= we;
      for (int b = 0; b < DATA_W/8; b++)
        if (we && wstrb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module huffman_axil_regs #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_W-1:0]            S_AWADDR,
  input  logic [2:0]                   S_AWPROT,
  input  logic                         S_AWVALID,
  output logic                         S_AWREADY,
  input  logic [DATA_W-1:0]            S_WDATA,
  input  logic [DATA_W/8-1:0]          S_WSTRB,
  input  logic                         S_WVALID,
  output logic                         S_WREADY,
  output logic [1:0]                   S_BRESP,
  output logic                         S_BVALID,
  input  logic                         S_BREADY,
  input  logic [ADDR_W-1:0]            S_ARADDR,
  input  logic [2:0]                   S_ARPROT,
  input  logic                         S_ARVALID,
  output logic                         S_ARREADY,
  output logic [DATA_W-1:0]            S_RDATA,
  output logic [1:0]                   S_RRESP,
  output logic                         S_RVALID,
  input  logic                         S_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  input  logic [DATA_W-1:0]            status_i
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int NB    = DATA_W / 8;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef HUFFMAN_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_D, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  logic unused;
  assign unused = ^{S_AWPROT, S_ARPROT, S_AWADDR[1:0], S_ARADDR[1:0]};

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  assign reg_q = regs;

  // ---------------- write channel ----------------
  wstate_t            wstate, wstate_nxt;
  logic [IDX_W-1:0]   aw_idx, wr_idx;
  logic [DATA_W-1:0]  wdata_l, wr_data;
  logic [NB-1:0]      wstrb_l, wr_strb;
  logic               aw_hs, w_hs, wr_go;

  // Readies are gated by reset so nothing is accepted while it is held.
  assign S_AWREADY = ~ARESET & ((wstate == W_IDLE) | (wstate == W_GOT_D));
  assign S_WREADY  = ~ARESET & ((wstate == W_IDLE) | (wstate == W_GOT_A));
  assign S_BVALID  = (wstate == W_RESP);
  assign aw_hs     = S_AWVALID & S_AWREADY;
  assign w_hs      = S_WVALID & S_WREADY;

  always_comb begin
    wstate_nxt = wstate;
    wr_go      = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_nxt = W_RESP;
          wr_go      = 1'b1;
        end else if (aw_hs) begin
          wstate_nxt = W_GOT_A;
        end else if (w_hs) begin
          wstate_nxt = W_GOT_D;
        end
      end
      W_GOT_A: if (w_hs) begin
        wstate_nxt = W_RESP;
        wr_go      = 1'b1;
      end
      W_GOT_D: if (aw_hs) begin
        wstate_nxt = W_RESP;
        wr_go      = 1'b1;
      end
      W_RESP:  if (S_BREADY) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Use the latched half of the transaction when it arrived earlier.
  assign wr_idx  = (wstate == W_GOT_A) ? aw_idx  : S_AWADDR[ADDR_W-1:2];
  assign wr_data = (wstate == W_GOT_D) ? wdata_l : S_WDATA;
  assign wr_strb = (wstate == W_GOT_D) ? wstrb_l : S_WSTRB;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      aw_idx  <= '0;
      wdata_l <= '0;
      wstrb_l <= '0;
      S_BRESP <= RESP_OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (aw_hs) aw_idx <= S_AWADDR[ADDR_W-1:2];
      if (w_hs) begin
        wdata_l <= S_WDATA;
        wstrb_l <= S_WSTRB;
      end
      if (wr_go) S_BRESP <= (wr_idx > STATUS_IDX) ? RESP_UNMAPPED : RESP_OKAY;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    huffman_axil_reg_word #(.DATA_W(DATA_W)) u_word (
      .clk   (ACLK),
      .rst   (ARESET),
      .we    (wr_go && (wr_idx == IDX_W'(i))),
      .wdata (wr_data),
      .wstrb (wr_strb),
      .q     (regs[i]),
      .pulse (reg_wr_pulse[i])
    );
  end

  // ---------------- read channel ----------------
  rstate_t            rstate, rstate_nxt;
  logic [IDX_W-1:0]   ar_idx;
  logic [DATA_W-1:0]  rd_val;
  logic [1:0]         rd_resp;
  logic               ar_hs;

  assign S_ARREADY = ~ARESET & (rstate == R_IDLE);
  assign S_RVALID  = (rstate == R_RESP);
  assign ar_hs     = S_ARVALID & S_ARREADY;
  assign ar_idx    = S_ARADDR[ADDR_W-1:2];

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IDX_W'(i)) rd_val = regs[i];
    if (ar_idx == STATUS_IDX)     rd_val  = status_i;
    else if (ar_idx > STATUS_IDX) rd_resp = RESP_UNMAPPED;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
      R_RESP:  if (S_RREADY) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate  <= R_IDLE;
      S_RDATA <= '0;
      S_RRESP <= RESP_OKAY;
    end else begin
      rstate <= rstate_nxt;
      if (ar_hs) begin
        S_RDATA <= rd_val;
        S_RRESP <= rd_resp;
      end
    end
  end
endmodule

// File: tb/tb_huffman_axil_regs.sv
// Bench for huffman_axil_regs: transaction-level model checked every cycle plus directed literals.
module tb_huffman_axil_regs;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 5;
`ifdef HUFFMAN_AXIL_SLVERR_EN
  localparam logic [1:0] UNM = 2'b10;
`else
  localparam logic [1:0] UNM = 2'b00;
`endif

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [ADDR_W-1:0] S_AWADDR = '0, S_ARADDR = '0;
  logic [2:0] S_AWPROT = '0, S_ARPROT = '0;
  logic S_AWVALID = 1'b0, S_WVALID = 1'b0, S_BREADY = 1'b0, S_ARVALID = 1'b0, S_RREADY = 1'b0;
  logic [31:0] S_WDATA = '0, status_i = '0;
  logic [3:0] S_WSTRB = '0;
  logic S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
  logic [1:0] S_BRESP, S_RRESP;
  logic [31:0] S_RDATA;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0] reg_wr_pulse;

  huffman_axil_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_i(status_i)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Transaction model: one outstanding write (address/data may arrive apart), one outstanding read.
  logic [31:0] m_regs [NUM_REGS] = '{default: 32'h0};
  bit          m_a_held = 0, m_d_held = 0, m_b_pend = 0, m_r_pend = 0;
  int          m_a_idx = 0, ridx;
  logic [31:0] m_data = '0, m_rdata = '0;
  logic [3:0]  m_strb = '0;
  logic [1:0]  m_bresp = '0, m_rresp = '0;
  logic [NUM_REGS-1:0] m_pulse = '0;
  int          pulse_cnt [NUM_REGS] = '{default: 0};
  bit          ex_aw, ex_w, ex_ar;

  function automatic logic [127:0] m_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  always @(negedge ACLK) begin
    ex_aw = !ARESET && !m_b_pend && !m_a_held;
    ex_w  = !ARESET && !m_b_pend && !m_d_held;
    ex_ar = !ARESET && !m_r_pend;
    chk("awready", S_AWREADY, ex_aw);
    chk("wready",  S_WREADY,  ex_w);
    chk("arready", S_ARREADY, ex_ar);
    chk("bvalid",  S_BVALID,  m_b_pend);
    chk("rvalid",  S_RVALID,  m_r_pend);
    chk("bresp",   S_BRESP,   m_bresp);
    chk("rresp",   S_RRESP,   m_rresp);
    chk("rdata",   S_RDATA,   m_rdata);
    chk("reg_q",   reg_q,     m_flat());
    chk("pulse",   reg_wr_pulse, m_pulse);
    for (int i = 0; i < NUM_REGS; i++) pulse_cnt[i] += int'(reg_wr_pulse[i]);
    // predict the coming rising edge
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      m_a_held = 0; m_d_held = 0; m_b_pend = 0; m_r_pend = 0;
      m_bresp = '0; m_rresp = '0; m_rdata = '0; m_pulse = '0;
    end else begin
      m_pulse = '0;
      if (m_b_pend && S_BREADY) m_b_pend = 0;
      if (m_r_pend && S_RREADY) m_r_pend = 0;
      if (S_ARVALID && ex_ar) begin
        ridx = int'(S_ARADDR[ADDR_W-1:2]);
        m_r_pend = 1;
        m_rresp  = (ridx > NUM_REGS) ? UNM : 2'b00;
        if (ridx < NUM_REGS)       m_rdata = m_regs[ridx];
        else if (ridx == NUM_REGS) m_rdata = status_i;
        else                       m_rdata = '0;
      end
      if (S_AWVALID && ex_aw) begin
        m_a_held = 1;
        m_a_idx  = int'(S_AWADDR[ADDR_W-1:2]);
      end
      if (S_WVALID && ex_w) begin
        m_d_held = 1;
        m_data   = S_WDATA;
        m_strb   = S_WSTRB;
      end
      if (m_a_held && m_d_held) begin
        if (m_a_idx < NUM_REGS) begin
          for (int b = 0; b < 4; b++)
            if (m_strb[b]) m_regs[m_a_idx][8*b +: 8] = m_data[8*b +: 8];
          m_pulse[m_a_idx] = 1'b1;
        end
        m_bresp  = (m_a_idx > NUM_REGS) ? UNM : 2'b00;
        m_b_pend = 1;
        m_a_held = 0;
        m_d_held = 0;
      end
    end
  end

  // All drivers change inputs 1 time unit after a rising edge.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit wait_resp,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, seen = 0;
    resp = 2'bxx;
    S_BREADY = 1'b0;
    for (int k = 0; k < 60 && !(aw_done && w_done); k++) begin
      if (k == aw_dly) begin S_AWADDR = addr; S_AWVALID = 1'b1; end
      if (k == w_dly)  begin S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1; end
      @(negedge ACLK);
      if (S_AWVALID && S_AWREADY) aw_done = 1;
      if (S_WVALID && S_WREADY)   w_done = 1;
      @(posedge ACLK); #1;
      if (aw_done) S_AWVALID = 1'b0;
      if (w_done)  S_WVALID  = 1'b0;
    end
    if (!(aw_done && w_done)) begin
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      tmo("write_addr_data");
      return;
    end
    if (!wait_resp) return;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge ACLK);
      if (S_BVALID) begin seen = 1; resp = S_BRESP; end
      @(posedge ACLK); #1;
    end
    if (!seen) begin tmo("write_resp"); return; end
    repeat (b_dly) begin @(posedge ACLK); #1; end
    S_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done = 0;
    data = 'x; resp = 2'bxx;
    S_RREADY = 1'b0; S_ARADDR = addr; S_ARVALID = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge ACLK);
      if (S_ARREADY) done = 1;
      @(posedge ACLK); #1;
    end
    S_ARVALID = 1'b0;
    if (!done) begin tmo("read_addr"); return; end
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge ACLK);
      if (S_RVALID) begin done = 1; data = S_RDATA; resp = S_RRESP; end
      @(posedge ACLK); #1;
    end
    if (!done) begin tmo("read_data"); return; end
    repeat (r_dly) begin @(posedge ACLK); #1; end
    S_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_RREADY = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r, br;
  bit          seen;

  initial begin
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_reg_q", reg_q, '0);
    chk("rst_bvalid", S_BVALID, 1'b0);
    chk("rst_rvalid", S_RVALID, 1'b0);
    @(posedge ACLK); #1;
    for (int i = 0; i < NUM_REGS; i++) pulse_cnt[i] = 0;

    // sequential write / readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i*4), 32'(i+1), 4'hF, 0, 0, 0, 1, br);
      chk($sformatf("seq_bresp%0d", i), br, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i*4), 0, d, r);
      chk($sformatf("seq_rdata%0d", i), d, 32'(i+1));
      chk($sformatf("seq_rresp%0d", i), r, 2'b00);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("pulse_cnt%0d", i), pulse_cnt[i], 1);

    // read and write of the same register on the same edge returns the old value
    fork
      axi_write(5'h04, 32'h99, 4'hF, 0, 0, 0, 1, br);
      axi_read(5'h04, 0, d, r);
    join
    chk("same_edge_old", d, 32'h2);
    chk("same_edge_new", reg_q[63:32], 32'h99);

    // channel ordering
    axi_write(5'h08, 32'hA5A5A5A5, 4'hF, 0, 3, 0, 1, br);
    chk("aw_first", reg_q[95:64], 32'hA5A5A5A5);
    axi_write(5'h08, 32'h0, 4'hF, 0, 0, 0, 1, br);
    axi_write(5'h08, 32'hA5A5A5A5, 4'hF, 3, 0, 0, 1, br);
    chk("w_first", reg_q[95:64], 32'hA5A5A5A5);

    // byte strobes, including an empty strobe
    axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1, br);
    axi_write(5'h01, 32'h12345678, 4'h5, 0, 0, 0, 1, br);
    axi_read(5'h00, 0, d, r);
    chk("strobe_merge", d, 32'hFF34FF78);
    axi_write(5'h00, 32'h0, 4'h0, 0, 0, 0, 1, br);
    chk("strobe_zero", reg_q[31:0], 32'hFF34FF78);

    // backpressure on both response channels
    axi_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 5, 1, br);
    axi_read(5'h0C, 5, d, r);
    chk("bp_rdata", d, 32'hCAFEF00D);

    // status word and unmapped space
    status_i = 32'hDEADBEEF;
    axi_read(5'h10, 0, d, r);
    chk("status_rdata", d, 32'hDEADBEEF);
    chk("status_rresp", r, 2'b00);
    axi_write(5'h10, 32'h11111111, 4'hF, 0, 0, 0, 1, br);
    chk("status_bresp", br, 2'b00);
    chk("status_wr_noeffect", reg_q, {32'hCAFEF00D, 32'hA5A5A5A5, 32'h00000099, 32'hFF34FF78});
    axi_read(5'h18, 0, d, r);
    chk("unm_rdata", d, 32'h0);
    chk("unm_rresp", r, UNM);
    axi_write(5'h1C, 32'h22222222, 4'hF, 0, 0, 0, 1, br);
    chk("unm_bresp", br, UNM);
    chk("unm_wr_noeffect", reg_q, {32'hCAFEF00D, 32'hA5A5A5A5, 32'h00000099, 32'hFF34FF78});

    // reset while a write response is pending
    axi_write(5'h04, 32'h55, 4'hF, 0, 0, 0, 0, br);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge ACLK);
      if (S_BVALID) seen = 1;
      @(posedge ACLK); #1;
    end
    if (!seen) tmo("rst_mid_bvalid");
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_mid_bvalid", S_BVALID, 1'b0);
    chk("rst_mid_reg_q", reg_q, '0);
    @(posedge ACLK); #1;
    axi_read(5'h04, 0, d, r);
    chk("rst_mid_readback", d, 32'h0);

    repeat (3) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/huffman_axil_regs.md
Name: huffman_axil_regs

Overview:
- AXI4-Lite slave register file that terminates the S00_AXI port of the Huffman IP. It answers the AXI4-Lite master on the other end of the link.
- Holds NUM_REGS 32-bit read/write control registers that feed the Huffman core, plus one read-only status word.
- Issues a one-cycle write-strobe pulse per register so the core can react to writes.
- Accepts one outstanding write and one outstanding read at a time. The write and read channels run independently.

Parameters:
- NUM_REGS, 4, number of R/W registers at word indices 0..NUM_REGS-1; legal range 1..(2**(ADDR_W-2))-1.
- ADDR_W, 5, AXI address width in bits; byte addresses 0x00..(2**ADDR_W)-1.
- DATA_W, 32, AXI data width; fixed at 32 (WSTRB is 4 bits).

Ports:
- ACLK, in, 1: single clock.
- ARESET, in, 1: synchronous, active-high reset.
- S_AWADDR, in, ADDR_W: write address.
- S_AWPROT, in, 3: ignored.
- S_AWVALID, in, 1: write address valid.
- S_AWREADY, out, 1: write address ready.
- S_WDATA, in, 32: write data.
- S_WSTRB, in, 4: byte enables.
- S_WVALID, in, 1: write data valid.
- S_WREADY, out, 1: write data ready.
- S_BRESP, out, 2: write response.
- S_BVALID, out, 1: write response valid.
- S_BREADY, in, 1: write response ready.
- S_ARADDR, in, ADDR_W: read address.
- S_ARPROT, in, 3: ignored.
- S_ARVALID, in, 1: read address valid.
- S_ARREADY, out, 1: read address ready.
- S_RDATA, out, 32: read data.
- S_RRESP, out, 2: read response.
- S_RVALID, out, 1: read data valid.
- S_RREADY, in, 1: read data ready.
- reg_q, out, NUM_REGS*32: register contents; register i occupies bits [32i+31:32i].
- reg_wr_pulse, out, NUM_REGS: bit i is high for one cycle after any write to register i.
- status_i, in, 32: core status word, readable at index NUM_REGS.

Behaviour:
- Clock and reset:
  - One clock, ACLK. Reset ARESET is synchronous and active-high.
  - Reset values: all registers 0; reg_q 0; reg_wr_pulse 0; S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID all 0; S_BRESP, S_RRESP, S_RDATA 0.
  - ARESET asserted mid-transaction aborts it. Pending BVALID/RVALID drop, any captured AW/W is discarded, and no register is written on that edge.
- Address decode:
  - index = ADDR[ADDR_W-1:2]; ADDR[1:0] is ignored.
  - Index < NUM_REGS selects a R/W register.
  - Index == NUM_REGS selects status: reads return status_i; writes are dropped and respond OKAY.
  - Any higher index is unmapped.
- Write FSM, states W_IDLE, W_GOT_A, W_GOT_D, W_RESP:
  - W_IDLE: S_AWREADY=1, S_WREADY=1.
  - AW handshake only: latch the address, go to W_GOT_A with AWREADY=0 and WREADY=1.
  - W handshake only: latch data and strobe, go to W_GOT_D with WREADY=0 and AWREADY=1.
  - Both handshakes in the same cycle, or completing the missing one: on that edge, write the register with byte-lane merge (lane b updated iff WSTRB[b]), set reg_wr_pulse[index] for the next cycle, set S_BVALID=1, and go to W_RESP.
  - Result: the register value and BVALID are both visible the cycle after the final handshake.
  - W_RESP: AWREADY=0, WREADY=0. Hold BVALID and BRESP stable until S_BREADY, then return to W_IDLE. No new write is accepted on the BREADY edge.
  - WSTRB=0 still produces a response and a pulse, with the data unchanged.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: S_ARREADY=1. On handshake, register RDATA and RRESP from the decode and set RVALID=1 the next cycle. Read latency is 1 cycle.
  - R_RESP: ARREADY=0. Hold RDATA, RRESP and RVALID stable until S_RREADY, then return to R_IDLE.
  - Unmapped reads return RDATA=0.
- Simultaneous events:
  - A read handshake on the same edge as a write to the same register returns the old value.
  - The status read samples status_i at the AR handshake edge.
- Responses: BRESP and RRESP are OKAY (2'b00) except as defined under Optional Feature.

Optional Feature:
- Macro: HUFFMAN_AXIL_SLVERR_EN.
- Defined: accesses to unmapped indices respond SLVERR (2'b10) on BRESP/RRESP. Unmapped writes modify nothing and raise no pulse; unmapped reads return 0.
- Undefined: unmapped accesses respond OKAY. Writes are silently dropped, reads return 0, and no pulse is raised.

Test Plan:
- Sequential write/readback: write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C (WSTRB=0xF), then read all four → RDATA 0x1..0x4, all responses OKAY; reg_wr_pulse bits 0..3 each pulse exactly once.
- Channel ordering: AWVALID 3 cycles before WVALID, and separately WVALID 3 cycles before AWVALID, writing 0xA5A5A5A5 to 0x08 → a single BVALID one cycle after the later handshake; reg_q[95:64]=0xA5A5A5A5.
- Byte strobes: reg0=0xFFFFFFFF, then write 0x12345678 with WSTRB=0x5 → readback 0xFF34FF78.
- Backpressure: hold BREADY=0 for 5 cycles and RREADY=0 for 5 cycles → BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY, WREADY and ARREADY stay 0 until released.
- Status and unmapped:
  - status_i=0xDEADBEEF, read 0x10 → 0xDEADBEEF, OKAY.
  - Write 0x10 → OKAY, no change.
  - Read 0x18 → RDATA 0, with RRESP SLVERR if HUFFMAN_AXIL_SLVERR_EN is defined, else OKAY.
- Reset mid-op: ARESET pulsed while BVALID=1 after a write of 0x55 to 0x04 → BVALID=0, reg_q all 0, readback 0x04 returns 0.
